qpsk_demodulate: RTL
====================

// Module: qpsk_demodulate
// PURPOSE
//  Receive-side counterpart of the QPSK modulator. Takes the signed 10-bit carrier-sample
//  stream (N samples per symbol) and correlates it against cos/sin references over each
//  symbol period. It decides one I bit and one Q bit per symbol and emits them as a dibit
//  with a one-cycle strobe. Sits between the channel/ADC sample path and the bit sink.
// PARAMETERS
//  SAMPLE_W   10   width of signed input sample
//  REF_W      8    width of signed cos/sin reference (+/-127)
//  N_SAMP     16   samples per symbol (power of 2, one carrier period)
//  ACC_W      22   correlator width = SAMPLE_W+REF_W+log2(N_SAMP)
//  THRESH     4096 low-confidence magnitude threshold (applies to |acc_i| and |acc_q|)
// PORTS
//  clk           in   1         system clock, rising edge
//  rst           in   1         synchronous reset, active-high
//  sample_in     in   SAMPLE_W  signed carrier sample
//  sample_valid  in   1         sample_in valid this cycle
//  sym_start     in   1         qualified by sample_valid: this sample is phase 0
//  Ichannel      out  1         decided I bit (held until next decision)
//  Qchannel      out  1         decided Q bit (held until next decision)
//  sym_valid     out  1         1-cycle strobe: new Ichannel/Qchannel
//  low_conf      out  1         valid with sym_valid: |acc_i|<THRESH or |acc_q|<THRESH
//  resync        out  1         1-cycle pulse: sym_start arrived at phase != 0 in RUN
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, phase=0, accumulators=0, pipeline valids cleared.
//  - Signal model: x[n] = sI*COS[n] + sQ*SIN[n], s=+1 for bit 1, -1 for bit 0;
//    COS[n]=round(127cos(2*pi*n/N_SAMP)), SIN[n]=round(127sin(2*pi*n/N_SAMP)).
//    Dibit encoding {I,Q}: 00,01,11,10 map to the modulator's Symbol00/01/11/10.
//  - FSM: IDLE -> RUN on (sample_valid & sym_start); samples before that are ignored.
//    RUN stays RUN; only rst returns to IDLE.
//  - Phase counter: increments per accepted sample (sample_valid=1 in RUN), wraps N-1->0.
//    sample_valid=0 holds phase and inserts a pipeline bubble; no timeout.
//  - Pipeline: S1 registers sample+phase; S2 registers products p_i=x*COS[ph],
//    p_q=x*SIN[ph] (signed, SAMPLE_W+REF_W bits, sign-extended); S3 accumulates.
//    Phase-0 product loads the accumulator (acc=p); others add (acc+=p). No saturation.
//  - Decision: when the phase N-1 product is accumulated, Ichannel=(acc_i>=0),
//    Qchannel=(acc_q>=0) (tie -> 1). low_conf is computed from the same final sums.
//    sym_valid pulses exactly 3 cycles after the edge that captured the phase N-1 sample,
//    with no bubbles in between; bubbles delay it 1 cycle each.
//  - Resync: sample_valid&sym_start in RUN at phase!=0: partial sums discarded, no
//    decision, this sample becomes phase 0, resync pulses 1 cycle (same latency as S1).
//    sym_start at phase 0 is a normal symbol start with no pulse.
//  - Back-to-back symbols: one sym_valid per N accepted samples; no dead cycles.
//  - rst mid-symbol: partial symbol dropped, no sym_valid, outputs to 0 next cycle.
// STRUCTURE
//  - Package qpsk_pkg: SAMPLE_W/REF_W/N_SAMP constants, COS/SIN LUT, dibit encodings.
//    The modulator symbol ROMs share the same package.
//  - Sub-module qpsk_carrier_rom: phase -> {cos,sin} signed REF_W, combinational.
//  - Top: FSM + phase counter, 3-stage MAC pipeline, decision/flag logic.
// TESTING
//  1. Reset: hold rst 3 cycles -> every output 0; samples with no sym_start -> no sym_valid.
//  2. Single symbol {I,Q}=10, x=2*COS[n]-2*SIN[n], sym_start on n=0 -> sym_valid 3 cycles
//     after n=15; Ichannel=1, Qchannel=0, low_conf=0.
//  3. Four back-to-back symbols 00,01,11,10 at amplitude 2 -> 4 strobes, 16 cycles
//     apart, with matching dibits.
//  4. Same stream with sample_valid=0 on every 3rd cycle -> identical dibits, strobes
//     delayed by the bubbles.
//  5. sym_start reasserted at phase 7 -> resync=1 for 1 cycle, no decision for the
//     partial symbol, next symbol decoded correctly.
//  6. x=0 for a symbol -> Ichannel=1, Qchannel=1, low_conf=1; rst at phase 9 of the
//     next symbol -> no strobe, state IDLE.

Source files
------------

// File: rtl/qpsk_pkg.sv
// ============================================================================
// qpsk_pkg : shared QPSK constants, carrier LUT and dibit encodings
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package qpsk_pkg;

    localparam int SAMPLE_W = 10;
    localparam int REF_W    = 8;
    localparam int N_SAMP   = 16;
    localparam int PH_W     = $clog2(N_SAMP);
    localparam int PROD_W   = SAMPLE_W + REF_W;
    localparam int ACC_W    = PROD_W + PH_W;
    localparam int THRESH   = 4096;

    typedef logic [1:0] dibit_t;
    localparam dibit_t SYM00 = 2'b00;
    localparam dibit_t SYM01 = 2'b01;
    localparam dibit_t SYM11 = 2'b11;
    localparam dibit_t SYM10 = 2'b10;

    // round(127*cos(2*pi*n/16)); the sine is the same table a quarter period late.
    function automatic logic signed [REF_W-1:0] cos_lut(input logic [PH_W-1:0] ph);
        logic signed [REF_W-1:0] v;
        v = '0;
        case (ph)
            4'd0:    v = 8'sd127;
            4'd1:    v = 8'sd117;
            4'd2:    v = 8'sd90;
            4'd3:    v = 8'sd49;
            4'd4:    v = 8'sd0;
            4'd5:    v = -8'sd49;
            4'd6:    v = -8'sd90;
            4'd7:    v = -8'sd117;
            4'd8:    v = -8'sd127;
            4'd9:    v = -8'sd117;
            4'd10:   v = -8'sd90;
            4'd11:   v = -8'sd49;
            4'd12:   v = 8'sd0;
            4'd13:   v = 8'sd49;
            4'd14:   v = 8'sd90;
            default: v = 8'sd117;
        endcase
        return v;
    endfunction

    function automatic logic signed [REF_W-1:0] sin_lut(input logic [PH_W-1:0] ph);
        return cos_lut(PH_W'(ph - PH_W'(N_SAMP / 4)));
    endfunction

endpackage

`default_nettype wire

// File: rtl/qpsk_carrier_rom.sv
// ============================================================================
// qpsk_carrier_rom : combinational phase -> {cos, sin} reference lookup
// Rev 1.0          : initial release
// ============================================================================
`default_nettype none

module qpsk_carrier_rom
    import qpsk_pkg::*;
(
    input  logic        [PH_W-1:0]  phase_i,
    output logic signed [REF_W-1:0] cos_o,
    output logic signed [REF_W-1:0] sin_o
);

    assign cos_o = cos_lut(phase_i);
    assign sin_o = sin_lut(phase_i);

endmodule

`default_nettype wire

// File: rtl/qpsk_demodulate.sv
// ============================================================================
// qpsk_demodulate : QPSK correlating demodulator, one dibit per carrier period
// Rev 1.0         : initial release
// ============================================================================
`default_nettype none

module qpsk_demodulate
    import qpsk_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       sample_valid,
    input  logic                       sym_start,
    output logic                       Ichannel,
    output logic                       Qchannel,
    output logic                       sym_valid,
    output logic                       low_conf,
    output logic                       resync
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic signed [ACC_W-1:0] THR_POS = ACC_W'(THRESH);
    localparam logic signed [ACC_W-1:0] THR_NEG = -THR_POS;

    logic [0:0]                 state_q, state_d;
    logic [PH_W-1:0]            phase_q, phase_d;
    logic                       resync_q, resync_d;

    logic                       s1_valid_q;
    logic signed [SAMPLE_W-1:0] s1_sample_q;
    logic [PH_W-1:0]            s1_phase_q;

    logic                       s2_valid_q, s2_first_q, s2_last_q;
    logic signed [PROD_W-1:0]   s2_pi_q, s2_pq_q;

    logic                       s3_last_q;
    logic signed [ACC_W-1:0]    acc_i_q, acc_q_q;

    logic                       ich_q, qch_q, sym_valid_q, low_conf_q;

    logic                       accept_w;
    logic [PH_W-1:0]            samp_ph_w;
    logic signed [REF_W-1:0]    cos_w, sin_w;
    logic signed [PROD_W-1:0]   pi_w, pq_w;
    logic                       low_conf_w;

    // A qualified sym_start always forces phase 0, whether it opens RUN or resyncs.
    assign accept_w  = sample_valid & ((state_q == ST_RUN) | sym_start);
    assign samp_ph_w = sym_start ? '0 : phase_q;

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        resync_d = 1'b0;
        if (sample_valid && sym_start) begin
            state_d  = ST_RUN;
            resync_d = (state_q == ST_RUN) && (phase_q != '0);
        end
        if (accept_w) begin
            phase_d = samp_ph_w + 1'b1;
        end
    end

    qpsk_carrier_rom u_rom (
        .phase_i (s1_phase_q),
        .cos_o   (cos_w),
        .sin_o   (sin_w)
    );

    assign pi_w = PROD_W'(s1_sample_q) * PROD_W'(cos_w);
    assign pq_w = PROD_W'(s1_sample_q) * PROD_W'(sin_w);

    assign low_conf_w = ((acc_i_q > THR_NEG) && (acc_i_q < THR_POS)) ||
                        ((acc_q_q > THR_NEG) && (acc_q_q < THR_POS));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            resync_q    <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_sample_q <= '0;
            s1_phase_q  <= '0;
            s2_valid_q  <= 1'b0;
            s2_first_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_pi_q     <= '0;
            s2_pq_q     <= '0;
            s3_last_q   <= 1'b0;
            acc_i_q     <= '0;
            acc_q_q     <= '0;
            ich_q       <= 1'b0;
            qch_q       <= 1'b0;
            sym_valid_q <= 1'b0;
            low_conf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            resync_q   <= resync_d;

            s1_valid_q <= accept_w;
            if (accept_w) begin
                s1_sample_q <= sample_in;
                s1_phase_q  <= samp_ph_w;
            end

            s2_valid_q <= s1_valid_q;
            s2_first_q <= s1_valid_q && (s1_phase_q == '0);
            s2_last_q  <= s1_valid_q && (s1_phase_q == PH_W'(N_SAMP - 1));
            s2_pi_q    <= pi_w;
            s2_pq_q    <= pq_w;

            // Phase-0 product loads, which also discards any partial sum after a resync.
            s3_last_q <= s2_valid_q && s2_last_q;
            if (s2_valid_q) begin
                if (s2_first_q) begin
                    acc_i_q <= ACC_W'(s2_pi_q);
                    acc_q_q <= ACC_W'(s2_pq_q);
                end else begin
                    acc_i_q <= acc_i_q + ACC_W'(s2_pi_q);
                    acc_q_q <= acc_q_q + ACC_W'(s2_pq_q);
                end
            end

            sym_valid_q <= s3_last_q;
            if (s3_last_q) begin
                ich_q      <= ~acc_i_q[ACC_W-1];
                qch_q      <= ~acc_q_q[ACC_W-1];
                low_conf_q <= low_conf_w;
            end
        end
    end

    assign Ichannel  = ich_q;
    assign Qchannel  = qch_q;
    assign sym_valid = sym_valid_q;
    assign low_conf  = low_conf_q;
    assign resync    = resync_q;

endmodule

`default_nettype wire
